store_serializer_32_8: RTL and testbench

Store-path counterpart of the load-side halfword sign extender. It accepts a 32-bit store request (byte, halfword or word) from the datapath and serializes it into single-byte writes to the byte-wide Data Memory, one byte per clock. Upper register bits are truncated according to size. Default byte order is big-endian, so the most significant byte goes to the lowest address; this matches how the load path concatenates do0:do1.

---
 rtl/store_serializer_32_8.sv | 130 +++++++++++++
 tb/tb_store_serializer_32_8.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/store_serializer_32_8.sv
// Store serializer: turns one byte/halfword/word store request into
// consecutive single-byte writes to a byte-wide data memory.
// Default byte order is big-endian (MSB to the lowest address).
// Optional macro STORE_LITTLE_ENDIAN_EN reverses the byte order.
module store_serializer_32_8 #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_di,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned IDX_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [IDX_W-1:0]  last, last_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [31:0]       data, data_n;
  logic              hs;
  logic              bad;
  logic [4:0]        shamt;

  // Next-state, request latching and byte-lane selection for the next cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    last_n  = last;
    base_n  = base;
    data_n  = data;
    hs      = req_valid && req_ready;
    bad     = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    case (state)
      IDLE: begin
        if (hs) begin
          if (bad) begin
            state_n = ERR;
          end else begin
            state_n = WRITE;
            base_n  = req_addr;
            data_n  = req_data;
            idx_n   = '0;
            case (req_size)
              2'b00:   last_n = IDX_W'(0);
              2'b01:   last_n = IDX_W'(1);
              default: last_n = IDX_W'(3);
            endcase
          end
        end
      end
      WRITE: begin
        if (idx == last) begin
          state_n = DONE;
        end else begin
          idx_n = idx + IDX_W'(1);
        end
      end
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase

`ifdef STORE_LITTLE_ENDIAN_EN
    shamt = {idx_n, 3'b000};
`else
    shamt = {last_n - idx_n, 3'b000};
`endif
  end

  // State and latched request registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      idx   <= '0;
      last  <= '0;
      base  <= '0;
      data  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      last  <= last_n;
      base  <= base_n;
      data  <= data_n;
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_ready <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_di    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      req_ready <= (state_n == IDLE);
      mem_we    <= (state_n == WRITE);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      err       <= (state_n == ERR);
      if (state_n == WRITE) begin
        mem_addr <= base_n + ADDR_W'(idx_n);
        mem_di   <= 8'(data_n >> shamt);
      end
    end
  end

endmodule

// File: tb/tb_store_serializer_32_8.sv
// Randomized self-checking bench for store_serializer_32_8 with a
// byte-order reference model computed from size and index arithmetic.
module tb_store_serializer_32_8;

  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_data = '0;
  logic [1:0]        req_size = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_di;
  logic              busy;
  logic              done;
  logic              err;

  int vectors = 0;
  int miscompares = 0;

  store_serializer_32_8 #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Reference: byte k of a store of 2**sz bytes.
  function automatic logic [7:0] exp_byte(input logic [31:0] d, input logic [1:0] sz, input int k);
    int n;
    int pos;
    n = 1 << sz;
`ifdef STORE_LITTLE_ENDIAN_EN
    pos = k;
`else
    pos = n - 1 - k;
`endif
    return 8'((d >> (8 * pos)) & 32'hff);
  endfunction

  function automatic bit exp_reject(input logic [31:0] a, input logic [1:0] sz);
    return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
  endfunction

  // Waits (bounded) until req_ready, sampled just after a rising edge.
  task automatic wait_ready(input string name);
    for (int c = 0; c < 20 && req_ready !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", name, req_ready);
    end
  endtask

  // Issues one store and checks every following cycle against the model.
  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz, input string name);
    int n;
    wait_ready(name);
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_data = d; req_size = sz;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_data = $urandom;
    if (exp_reject(a, sz)) begin
      vectors++;
      if (err !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL %s err_pulse: err=%b we=%b done=%b busy=%b required 1 0 0 1", name, err, mem_we, done, busy);
      end
      @(posedge clk); #1;
      vectors++;
      if (err !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s err_end: err=%b we=%b ready=%b busy=%b required 0 0 1 0", name, err, mem_we, req_ready, busy);
      end
    end else begin
      n = 1 << sz;
      for (int k = 0; k < n; k++) begin
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== a + k || mem_di !== exp_byte(d, sz, k) || done !== 1'b0) begin
          miscompares++;
          $display("FAIL %s write%0d: we=%b addr=%h di=%h done=%b required 1 %h %h 0",
                   name, k, mem_we, mem_addr, mem_di, done, a + k, exp_byte(d, sz, k));
        end
        @(posedge clk); #1;
      end
      vectors++;
      if (done !== 1'b1 || mem_we !== 1'b0 || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s done_pulse: done=%b we=%b ready=%b required 1 0 0", name, done, mem_we, req_ready);
      end
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL %s done_end: done=%b ready=%b busy=%b required 0 1 0", name, done, req_ready, busy);
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, mem_we, mem_addr, mem_di, busy, done, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_values: ready=%b we=%b addr=%h di=%h busy=%b done=%b err=%b required all 0",
               req_ready, mem_we, mem_addr, mem_di, busy, done, err);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", req_ready, busy);
    end
  endtask

  task automatic test_reset_mid_store;
    logic [31:0] d;
    d = $urandom;
    wait_ready("reset_mid");
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h40; req_data = d; req_size = 2'b10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h41 || mem_di !== exp_byte(d, 2'b10, 1)) begin
      miscompares++;
      $display("FAIL reset_mid second_byte: we=%b addr=%h di=%h required 1 41 %h", mem_we, mem_addr, mem_di, exp_byte(d, 2'b10, 1));
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if ({req_ready, mem_we, mem_addr, mem_di, busy, done, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid async_clear: ready=%b we=%b addr=%h di=%h busy=%b done=%b err=%b required all 0",
               req_ready, mem_we, mem_addr, mem_di, busy, done, err);
    end
    @(negedge clk) reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      vectors++;
      if (done !== 1'b0 || mem_we !== 1'b0 || req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_mid after%0d: done=%b we=%b ready=%b required 0 0 1", c, done, mem_we, req_ready);
      end
    end
  endtask

  task automatic test_directed;
    run_store(32'h100, 32'hDEADBEEF, 2'b10, "word_deadbeef");
    run_store(32'h22,  32'h1234ABCD, 2'b01, "half_22");
    run_store(32'h7,   32'hFFFFFF5A, 2'b00, "byte_7");
  endtask

  task automatic test_errors;
    run_store(32'h3,   32'h11223344, 2'b01, "err_half_3");
    run_store(32'h102, 32'h55667788, 2'b10, "err_word_102");
    run_store(32'h80,  32'h99AABBCC, 2'b11, "err_reserved");
  endtask

  task automatic test_held_valid;
    logic [31:0] a_dat;
    logic [31:0] b_dat;
    a_dat = $urandom;
    wait_ready("held_valid");
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h200; req_data = a_dat; req_size = 2'b10;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (mem_we !== 1'b1 || mem_addr !== 32'h200 + k || mem_di !== exp_byte(a_dat, 2'b10, k)) begin
        miscompares++;
        $display("FAIL held_valid write%0d: we=%b addr=%h di=%h required 1 %h %h",
                 k, mem_we, mem_addr, mem_di, 32'h200 + k, exp_byte(a_dat, 2'b10, k));
      end
      @(negedge clk) req_data = $urandom;
      @(posedge clk); #1;
    end
    vectors++;
    if (done !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL held_valid done: done=%b we=%b required 1 0", done, mem_we);
    end
    b_dat = $urandom;
    @(negedge clk) req_data = b_dat;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL held_valid idle: ready=%b we=%b required 1 0", req_ready, mem_we);
    end
    b_dat = $urandom;
    @(negedge clk) req_data = b_dat;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_di !== exp_byte(b_dat, 2'b10, 0)) begin
      miscompares++;
      $display("FAIL held_valid reaccept: we=%b addr=%h di=%h required 1 200 %h", mem_we, mem_addr, mem_di, exp_byte(b_dat, 2'b10, 0));
    end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    logic [31:0] a;
    logic [1:0]  sz;
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 3) != 0) a = a & ~32'h3;
      run_store(a, $urandom, sz, "random");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_errors();
    test_reset_mid_store();
    test_held_valid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
